// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer bus: request, MFHI/MFLO read port and status.
// The EX side is the master and the sequencer is the slave.
interface mdu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             mf_req;
  logic             mf_sel;
  logic             flush;
  logic [WIDTH-1:0] mf_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, opa, opb, mf_req, mf_sel, flush,
    input  mf_data, hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, opa, opb, mf_req, mf_sel, flush,
    output mf_data, hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative MULTU/DIVU sequencer that owns HI/LO and holds the pipeline while an op is in flight.
// Multiply is shift-add and divide is restoring; both retire one bit per cycle.
module mdu_sequencer #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  mdu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                op_q, op_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    oper_q, oper_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    low_q, low_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                done_s;

  logic [WIDTH:0]      mul_sum_s;
  logic [WIDTH:0]      div_sh_s;
  logic [WIDTH:0]      div_diff_s;
  logic                div_ge_s;
  logic [WIDTH-1:0]    step_acc_s;
  logic [WIDTH-1:0]    step_low_s;

  // One multiply or divide iteration on the shared {acc, low} pair.
  // acc/low are product-high/low for MULTU and remainder/quotient for DIVU.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q};
    div_sh_s   = {acc_q, low_q[WIDTH-1]};
    div_diff_s = div_sh_s - {1'b0, oper_q};
    div_ge_s   = (div_sh_s >= {1'b0, oper_q});
    step_acc_s = acc_q;
    step_low_s = low_q;
    if (op_q == 1'b0) begin
      if (low_q[0]) begin
        mul_sum_s = {1'b0, acc_q} + {1'b0, oper_q};
      end else begin
        mul_sum_s = {1'b0, acc_q};
      end
      step_acc_s = mul_sum_s[WIDTH:1];
      step_low_s = {mul_sum_s[0], low_q[WIDTH-1:1]};
    end else begin
      if (div_ge_s) begin
        step_acc_s = div_diff_s[WIDTH-1:0];
        step_low_s = {low_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc_s = div_sh_s[WIDTH-1:0];
        step_low_s = {low_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Next-state logic: accept, iterate, retire into HI/LO; flush wins over everything.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    oper_d  = oper_q;
    acc_d   = acc_q;
    low_d   = low_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d   = bus.op;
          oper_d = bus.op ? bus.opb : bus.opa;
          if (bus.op && (bus.opb == {WIDTH{1'b0}})) begin
            // Divide by zero skips iteration: remainder = dividend, quotient = all ones.
            acc_d   = bus.opa;
            low_d   = {WIDTH{1'b1}};
            state_d = S_FIN;
          end else begin
            cnt_d   = CNT_BITS'(WIDTH);
            acc_d   = {WIDTH{1'b0}};
            low_d   = bus.op ? bus.opa : bus.opb;
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
          acc_d = step_acc_s;
          low_d = step_low_s;
          if (cnt_q == CNT_BITS'(1)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_FIN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = acc_q;
          lo_d    = low_q;
          done_s  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      cnt_q   <= {CNT_BITS{1'b0}};
      oper_q  <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      low_q   <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      oper_q  <= oper_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.mf_data = bus.mf_sel ? hi_q : lo_q;
  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = done_s;
  assign bus.stall   = (bus.start || bus.mf_req) && (state_q != S_IDLE);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: multiply, divide, divide-by-zero, MF stall, flush and async reset.
module tb_mdu_sequencer;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   n;

  mdu_sequencer_if #(.WIDTH(W)) bus ();

  mdu_sequencer #(.WIDTH(W), .CNT_BITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Called in cycle N+1; returns in the done cycle with n = offset from N.
  task automatic wait_done(input string tag, input int exp_cyc);
    n = 1;
    while (!bus.done && n < 80) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_cyc));
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.opa    = 32'd0;
    bus.opb    = 32'd0;
    bus.mf_req = 1'b0;
    bus.mf_sel = 1'b0;
    bus.flush  = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    tick();

    // 7 * 6: busy for N+1..N+32, done in N+33
    issue(1'b0, 32'd7, 32'd6);
    for (int i = 1; i <= 32; i++) begin
      chk("mul_busy", 64'(bus.busy), 64'd1);
      chk("mul_nodone", 64'(bus.done), 64'd0);
      tick();
    end
    chk("mul_done", 64'(bus.done), 64'd1);
    chk("mul_fin_busy", 64'(bus.busy), 64'd0);
    chk("mul_stall", 64'(bus.stall), 64'd0);
    tick();
    chk("mul_hi", 64'(bus.hi), 64'd0);
    chk("mul_lo", 64'(bus.lo), 64'd42);
    chk("mul_done_once", 64'(bus.done), 64'd0);

    // Max multiply, then back-to-back divide in the IDLE cycle after FIN
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulmax_lat", 33);
    tick();
    chk("mulmax_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    chk("mulmax_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.opa   = 32'd100;
    bus.opb   = 32'd7;
    #1;
    chk("b2b_stall", 64'(bus.stall), 64'd0);
    tick();
    bus.start = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done("div_lat", 33);
    tick();
    chk("div_hi", 64'(bus.hi), 64'd2);
    chk("div_lo", 64'(bus.lo), 64'd14);

    // Divide by zero completes in N+1 without RUN
    issue(1'b1, 32'd5, 32'd0);
    chk("dz_done", 64'(bus.done), 64'd1);
    chk("dz_busy", 64'(bus.busy), 64'd0);
    tick();
    chk("dz_hi", 64'(bus.hi), 64'd5);
    chk("dz_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFF);

    // MFLO request held from N+5 stalls until FIN, then returns the new LO
    issue(1'b0, 32'd3, 32'd5);
    for (int i = 1; i < 5; i++) tick();
    bus.mf_req = 1'b1;
    bus.mf_sel = 1'b0;
    #1;
    n = 5;
    while (!bus.done && n < 80) begin
      chk("mf_stall", 64'(bus.stall), 64'd1);
      tick();
      n++;
    end
    chk("mf_lat", 64'(n), 64'd33);
    chk("mf_stall_fin", 64'(bus.stall), 64'd1);
    tick();
    chk("mf_stall_idle", 64'(bus.stall), 64'd0);
    chk("mf_data", 64'(bus.mf_data), 64'd15);
    bus.mf_sel = 1'b1;
    #1;
    chk("mf_data_hi", 64'(bus.mf_data), 64'd0);
    bus.mf_req = 1'b0;

    // Restore HI/LO to 2/14, then flush a divide in RUN cycle 10 with an ignored start
    issue(1'b1, 32'd100, 32'd7);
    wait_done("div2_lat", 33);
    tick();
    issue(1'b1, 32'd1000, 32'd3);
    for (int i = 1; i < 5; i++) tick();
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.opa   = 32'd9;
    bus.opb   = 32'd9;
    #1;
    chk("busy_start_stall", 64'(bus.stall), 64'd1);
    tick();
    bus.start = 1'b0;
    for (int i = 6; i < 10; i++) tick();
    chk("fl_busy_pre", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    #1;
    chk("fl_nodone", 64'(bus.done), 64'd0);
    tick();
    bus.flush = 1'b0;
    chk("fl_idle", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 40; i++) begin
      chk("fl_quiet", 64'({bus.busy, bus.done}), 64'd0);
      tick();
    end
    chk("fl_hi", 64'(bus.hi), 64'd2);
    chk("fl_lo", 64'(bus.lo), 64'd14);

    // Async reset mid-RUN clears everything immediately
    issue(1'b0, 32'd9, 32'd9);
    for (int i = 1; i < 8; i++) tick();
    bus.mf_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(bus.busy), 64'd0);
    chk("ar_done", 64'(bus.done), 64'd0);
    chk("ar_stall", 64'(bus.stall), 64'd0);
    chk("ar_hi", 64'(bus.hi), 64'd0);
    chk("ar_lo", 64'(bus.lo), 64'd0);
    bus.mf_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    issue(1'b0, 32'd2, 32'd2);
    wait_done("ar_mul_lat", 33);
    tick();
    chk("ar_mul_lo", 64'(bus.lo), 64'd4);
    chk("ar_mul_hi", 64'(bus.hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer placed beside the EX stage ALU.
- Accepts one MULTU/DIVU request per operation from EX and runs an iterative shift-add multiply or restoring divide, one bit per cycle.
- Owns the HI/LO registers.
- Stalls the pipeline when EX issues a new MDU op or an MFHI/MFLO while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_BITS, 6, width of the iteration counter; must satisfy 2^CNT_BITS > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  EX presents an MDU op this cycle.
- op  input  1  0 = MULTU, 1 = DIVU.
- opa  input  WIDTH  rdata1 (multiplicand / dividend).
- opb  input  WIDTH  rdata2 (multiplier / divisor).
- mf_req  input  1  EX executing MFHI or MFLO this cycle.
- mf_sel  input  1  0 = LO, 1 = HI.
- flush  input  1  synchronous abort of an in-flight op.
- mf_data  output  WIDTH  combinational HI or LO selected by mf_sel.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  high while state == RUN.
- done  output  1  one-cycle pulse when HI/LO are updated by a completed op.
- stall  output  1  pipeline hold request to IF/ID/EX.

Behaviour:
- Reset: async on rst_n low. State = IDLE, hi = 0, lo = 0, done = 0, counter = 0, internal accumulators = 0. Reset mid-operation discards the op; HI/LO read 0 after release.
- States: IDLE, RUN, FIN.
- IDLE -> RUN when start = 1 and flush = 0.
  - Latch op, opa, opb.
  - Counter = WIDTH.
  - Multiply: acc = 0, mplier = opb.
  - Divide: rem = 0, quo = opa.
- IDLE divide-by-zero: if op = 1 and opb = 0, go IDLE -> FIN directly with hi = opa, lo = all ones.
- RUN, one iteration per cycle, counter decrements.
  - MULTU: if mplier[0], add the multiplicand into the upper half of a 2*WIDTH product (WIDTH+1-bit carry kept), then shift the product right 1.
  - DIVU (restoring): shift {rem, quo} left 1; if rem >= divisor, subtract and set quo[0] = 1.
- RUN -> FIN when counter reaches 1 and that iteration completes, i.e. after exactly WIDTH RUN cycles.
- FIN: load HI/LO, then -> IDLE next cycle.
  - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
  - Divide: hi = remainder, lo = quotient.
  - done = 1 for exactly the FIN cycle; HI/LO outputs show new values from the cycle after FIN.
- Latency: start sampled at edge N, so done is high in cycle N+WIDTH+1 and HI/LO are valid in cycle N+WIDTH+2. Divide-by-zero: done in cycle N+1.
- stall = (start | mf_req) & (state != IDLE).
  - Upstream holds start/mf_req stable while stalled.
  - A start seen while not IDLE is ignored, never queued.
  - stall deasserts in the IDLE cycle after FIN, in which the held request is accepted or the MF read returns updated data.
- mf_data = mf_sel ? hi : lo, purely combinational. It is valid only when stall = 0.
- flush:
  - In RUN or FIN: -> IDLE next cycle; HI/LO unchanged; no done pulse.
  - In IDLE: blocks acceptance of start.
  - Flush has priority over a simultaneous final iteration.
- Back-to-back: a start in the IDLE cycle right after FIN is accepted with no bubble.
- Unsigned arithmetic only. No overflow condition for multiply, since the 2*WIDTH product is exact.

Test Plan:
- Reset, then start MULTU opa=7 opb=6 at edge N -> busy for cycles N+1..N+32, done in N+33, then hi=0 lo=42; stall stays 0 with no further requests.
- MULTU opa=FFFFFFFF opb=FFFFFFFF -> hi=FFFFFFFE lo=00000001. Then DIVU opa=100 opb=7 issued the cycle after FIN -> accepted immediately; after 33 cycles hi=2 lo=14.
- DIVU opa=5 opb=0 -> done in the next cycle, hi=5 lo=FFFFFFFF, busy never asserts.
- MULTU 3*5 in progress, mf_req=1 mf_sel=0 held from cycle N+5 -> stall=1 until FIN. In the following IDLE cycle stall=0 and mf_data=15.
- Start a DIVU, assert flush in RUN cycle 10 -> IDLE next cycle, no done pulse, HI/LO keep prior values (hi=2 lo=14). Also drive start while busy -> ignored.
- Start a MULTU, pull rst_n low asynchronously mid-RUN -> busy, done, stall, hi, lo all 0 immediately. After release, a new MULTU 2*2 yields lo=4.
